i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arb_pkg.sv | 28 ++
 rtl/i2c_arbiter_rr_picker.sv | 37 +++
 rtl/i2c_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
// The timeout watchdog is only built when I2C_ARB_TIMEOUT_EN is defined.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } arb_state_t;

    localparam int ADDR_W          = 7;
    localparam int REPS_W          = 2;
    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 100000;
    localparam int TMO_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT);

    // Counter only ever needs to reach TIMEOUT-1.
    function automatic int tmo_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest requester above 'last' wins,
// otherwise wrap around to the lowest requester overall.
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = idx_width(NREQ_DEFAULT)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pool;
    logic            found;

    always_comb begin
        upper = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = req[i] && (i > int'(last));
        end
        pool  = (|upper) ? upper : req;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && pool[i]) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     mclk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [REPS_W*NREQ-1:0]   req_reps,
    input  logic                     done,
    input  logic                     ack_err,
    output logic                     startM,
    output logic [ADDR_W-1:0]        i2c_addr,
    output logic                     i2c_rw,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err
);

    localparam int IW = idx_width(NREQ);

    arb_state_t         state;
    logic [IW-1:0]      last;
    logic [IW-1:0]      owner;
    logic [REPS_W-1:0]  rep_cnt;
    logic               armed;

    logic [NREQ-1:0]    win_oh;
    logic               win_valid;
    logic [IW-1:0]      win_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_rw;
    logic [REPS_W-1:0]  sel_reps;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = tmo_width(TIMEOUT);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    generate
        if (TIMEOUT < 1) begin : g_no_watchdog
        end
    endgenerate
`endif

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (req),
        .last  (last),
        .win   (win_oh),
        .valid (win_valid)
    );

    always_comb begin
        win_idx  = '0;
        sel_addr = '0;
        sel_rw   = 1'b0;
        sel_reps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = IW'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_rw   = req_rw[i];
                sel_reps = req_reps[i*REPS_W +: REPS_W];
            end
        end
    end

    // 'armed' holds off any grant on the first edge after reset is released.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= IW'(NREQ - 1);
            owner    <= '0;
            rep_cnt  <= '0;
            armed    <= 1'b0;
            startM   <= 1'b0;
            i2c_addr <= '0;
            i2c_rw   <= 1'b0;
            gnt      <= '0;
            busy     <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            armed    <= 1'b1;
            startM   <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    if (armed && win_valid) begin
                        state    <= START;
                        startM   <= 1'b1;
                        busy     <= 1'b1;
                        gnt      <= win_oh;
                        owner    <= win_idx;
                        i2c_addr <= sel_addr;
                        i2c_rw   <= sel_rw;
                        rep_cnt  <= sel_reps;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (done) begin
                        if (ack_err) begin
                            state   <= ERR;
                            req_err <= gnt;
                        end else if (rep_cnt == '0) begin
                            state    <= DONE;
                            req_done <= gnt;
                        end else begin
                            rep_cnt <= rep_cnt - 1'b1;
                            state   <= START;
                            startM  <= 1'b1;
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state   <= ERR;
                        req_err <= gnt;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE, ERR: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    last  <= owner;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
